// File: rtl/uart_axis_checker.sv
// Stimulus/response checker for UART-attached DUTs over AXI-stream.
// Forwards stimulus, queues expected bytes, scores responses in order.
module uart_axis_checker #(
    parameter int DATA_WIDTH     = 8,
    parameter int DEPTH          = 16,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      clear_i,
    input  logic [2*DATA_WIDTH-1:0]   cmd_tdata_i,
    input  logic                      cmd_tvalid_i,
    output logic                      cmd_tready_o,
    output logic [DATA_WIDTH-1:0]     tx_tdata_o,
    output logic                      tx_tvalid_o,
    input  logic                      tx_tready_i,
    input  logic [DATA_WIDTH-1:0]     rx_tdata_i,
    input  logic                      rx_tvalid_i,
    output logic                      rx_tready_o,
    output logic [CNT_WIDTH-1:0]      pass_cnt_o,
    output logic [CNT_WIDTH-1:0]      fail_cnt_o,
    output logic [CNT_WIDTH-1:0]      unexp_cnt_o,
    output logic [$clog2(DEPTH):0]    outstanding_o,
    output logic                      mismatch_o,
    output logic                      timeout_o,
    output logic [DATA_WIDTH-1:0]     last_rx_o,
    output logic [DATA_WIDTH-1:0]     last_exp_o,
    output logic                      idle_o
);

    localparam int AW  = $clog2(DEPTH);
    localparam int OW  = AW + 1;
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW1 = CNT_WIDTH + 1;

    localparam logic [OW-1:0]        FULL_CNT = OW'(DEPTH);
    localparam logic [TW-1:0]        TMAX     = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_TOUT
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         rd_ptr;
    logic [AW-1:0]         wr_ptr;
    logic [OW-1:0]         count;
    logic [OW-1:0]         count_nxt;
    logic [TW-1:0]         timer;
    logic                  rx_rdy;

    logic                  full;
    logic                  push;
    logic                  rx_hs;
    logic                  tout_pop;
    logic                  do_cmp;
    logic                  do_unexp;
    logic                  match;
    logic [1:0]            n_pop;
    logic [1:0]            fail_inc;
    logic [DATA_WIDTH-1:0] exp_in;
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] cmp_exp;

    function automatic logic [CNT_WIDTH-1:0] sat_add(
        input logic [CNT_WIDTH-1:0] a,
        input logic [1:0]           b
    );
        logic [CNT_WIDTH:0] s;
        s = {1'b0, a} + CW1'(b);
        return s[CNT_WIDTH] ? CNT_MAX : s[CNT_WIDTH-1:0];
    endfunction

    assign exp_in        = cmd_tdata_i[2*DATA_WIDTH-1:DATA_WIDTH];
    assign tx_tdata_o    = cmd_tdata_i[DATA_WIDTH-1:0];
    assign full          = (count == FULL_CNT);
    assign tx_tvalid_o   = cmd_tvalid_i && !full;
    assign cmd_tready_o  = tx_tready_i && !full && !clear_i;
    assign push          = cmd_tvalid_i && cmd_tready_o;
    assign rx_tready_o   = rx_rdy;
    assign rx_hs         = rx_tvalid_i && rx_rdy && !clear_i;
    assign outstanding_o = count;
    assign idle_o        = (count == '0) && !cmd_tvalid_i;

    // A timed-out head is retired this cycle, so a concurrent
    // response is scored against the entry behind it.
    assign tout_pop = (state == S_TOUT);
    assign head     = mem[rd_ptr];
    assign cmp_exp  = tout_pop ? mem[rd_ptr + AW'(1)] : head;
    assign do_cmp   = rx_hs && (count > {{(OW-1){1'b0}}, tout_pop});
    assign do_unexp = rx_hs && !do_cmp;
    assign match    = (rx_tdata_i == cmp_exp);
    assign n_pop    = {1'b0, tout_pop} + {1'b0, do_cmp};
    assign fail_inc = {1'b0, tout_pop} + {1'b0, do_cmp && !match};
    assign count_nxt = count + OW'(push) - OW'(n_pop);

    // Expected-value storage, written on each tx handshake
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= exp_in;
        end
    end

    // Wait/timeout FSM with FIFO pointers, counters and result registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= S_IDLE;
            timer       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            rx_rdy      <= 1'b0;
            pass_cnt_o  <= '0;
            fail_cnt_o  <= '0;
            unexp_cnt_o <= '0;
            mismatch_o  <= 1'b0;
            timeout_o   <= 1'b0;
            last_rx_o   <= '0;
            last_exp_o  <= '0;
        end else if (clear_i) begin
            state       <= S_IDLE;
            timer       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            rx_rdy      <= 1'b1;
            pass_cnt_o  <= '0;
            fail_cnt_o  <= '0;
            unexp_cnt_o <= '0;
            mismatch_o  <= 1'b0;
            timeout_o   <= 1'b0;
            last_rx_o   <= '0;
            last_exp_o  <= '0;
        end else begin
            rx_rdy     <= 1'b1;
            count      <= count_nxt;
            rd_ptr     <= rd_ptr + AW'(n_pop);
            mismatch_o <= do_cmp && !match;
            fail_cnt_o <= sat_add(fail_cnt_o, fail_inc);
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (tout_pop) begin
                timeout_o  <= 1'b1;
                last_exp_o <= head;
            end
            if (do_cmp) begin
                last_rx_o  <= rx_tdata_i;
                last_exp_o <= cmp_exp;
            end
            if (do_cmp && match) begin
                pass_cnt_o <= sat_add(pass_cnt_o, 2'd1);
            end
            if (do_unexp) begin
                unexp_cnt_o <= sat_add(unexp_cnt_o, 2'd1);
            end
            unique case (state)
                S_IDLE: begin
                    timer <= '0;
                    if (push) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (rx_hs) begin
                        timer <= '0;
                        if (count_nxt == '0) begin
                            state <= S_IDLE;
                        end
                    end else if (timer == TMAX) begin
                        state <= S_TOUT;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_TOUT: begin
                    timer <= '0;
                    state <= (count_nxt == '0) ? S_IDLE : S_WAIT;
                end
                default: begin
                    timer <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_axis_checker.sv
// Self-checking bench for uart_axis_checker: directed scenarios
// plus randomized traffic scored against a queue-based model.
module tb_uart_axis_checker;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int TO    = 100;
    localparam int CW    = 16;
    localparam int OW    = $clog2(DEPTH) + 1;
    localparam int CMAX  = (1 << CW) - 1;

    logic            clk        = 1'b0;
    logic            rst_n      = 1'b0;
    logic            clear      = 1'b0;
    logic [2*DW-1:0] cmd_tdata  = '0;
    logic            cmd_tvalid = 1'b0;
    logic            cmd_tready;
    logic [DW-1:0]   tx_tdata;
    logic            tx_tvalid;
    logic            tx_tready  = 1'b0;
    logic [DW-1:0]   rx_tdata   = '0;
    logic            rx_tvalid  = 1'b0;
    logic            rx_tready;
    logic [CW-1:0]   pass_cnt;
    logic [CW-1:0]   fail_cnt;
    logic [CW-1:0]   unexp_cnt;
    logic [OW-1:0]   outstanding;
    logic            mismatch;
    logic            timeout;
    logic [DW-1:0]   last_rx;
    logic [DW-1:0]   last_exp;
    logic            idle;

    int checks = 0;
    int fails  = 0;

    uart_axis_checker #(
        .DATA_WIDTH    (DW),
        .DEPTH         (DEPTH),
        .TIMEOUT_CYCLES(TO),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .clear_i      (clear),
        .cmd_tdata_i  (cmd_tdata),
        .cmd_tvalid_i (cmd_tvalid),
        .cmd_tready_o (cmd_tready),
        .tx_tdata_o   (tx_tdata),
        .tx_tvalid_o  (tx_tvalid),
        .tx_tready_i  (tx_tready),
        .rx_tdata_i   (rx_tdata),
        .rx_tvalid_i  (rx_tvalid),
        .rx_tready_o  (rx_tready),
        .pass_cnt_o   (pass_cnt),
        .fail_cnt_o   (fail_cnt),
        .unexp_cnt_o  (unexp_cnt),
        .outstanding_o(outstanding),
        .mismatch_o   (mismatch),
        .timeout_o    (timeout),
        .last_rx_o    (last_rx),
        .last_exp_o   (last_exp),
        .idle_o       (idle)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of expected bytes plus the age of the oldest
    logic [DW-1:0] mq[$];
    int            m_pass     = 0;
    int            m_fail     = 0;
    int            m_unexp    = 0;
    int            m_age      = 0;
    bit            m_due      = 1'b0;
    bit            m_timeout  = 1'b0;
    bit            m_mismatch = 1'b0;
    bit            m_rxrdy    = 1'b0;
    logic [DW-1:0] m_last_rx  = '0;
    logic [DW-1:0] m_last_exp = '0;

    task automatic model_clear(input bit rdy);
        mq.delete();
        m_pass     = 0;
        m_fail     = 0;
        m_unexp    = 0;
        m_age      = 0;
        m_due      = 1'b0;
        m_timeout  = 1'b0;
        m_mismatch = 1'b0;
        m_rxrdy    = rdy;
        m_last_rx  = '0;
        m_last_exp = '0;
    endtask

    task automatic model_step();
        bit            push;
        bit            rx;
        bit            timed_out;
        logic [DW-1:0] e;
        push       = cmd_tvalid && tx_tready && (mq.size() < DEPTH);
        rx         = rx_tvalid && m_rxrdy;
        timed_out  = m_due;
        m_mismatch = 1'b0;
        m_rxrdy    = 1'b1;
        if (timed_out) begin
            m_last_exp = mq.pop_front();
            if (m_fail < CMAX) m_fail++;
            m_timeout = 1'b1;
            m_due     = 1'b0;
            m_age     = 0;
        end
        if (rx && mq.size() > 0) begin
            e          = mq.pop_front();
            m_last_rx  = rx_tdata;
            m_last_exp = e;
            m_age      = 0;
            if (e == rx_tdata) begin
                if (m_pass < CMAX) m_pass++;
            end else begin
                if (m_fail < CMAX) m_fail++;
                m_mismatch = 1'b1;
            end
        end else if (rx) begin
            if (m_unexp < CMAX) m_unexp++;
        end else if (!timed_out && mq.size() > 0) begin
            if (m_age == TO - 1) m_due = 1'b1;
            else m_age++;
        end
        if (push) begin
            if (mq.size() == 0) m_age = 0;
            mq.push_back(cmd_tdata[2*DW-1:DW]);
        end
    endtask

    // Advance the model on every clock edge, reset asynchronously
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_clear(1'b0);
        else if (clear) model_clear(1'b1);
        else model_step();
    end

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic send_cmd(input logic [DW-1:0] e, input logic [DW-1:0] s, output bit ok);
        bit hs;
        ok         = 1'b0;
        cmd_tdata  = {e, s};
        cmd_tvalid = 1'b1;
        tx_tready  = 1'b1;
        for (int i = 0; i < 50; i++) begin
            #1;
            hs = cmd_tready;
            @(negedge clk);
            if (hs) begin
                ok = 1'b1;
                break;
            end
        end
        cmd_tvalid = 1'b0;
    endtask

    task automatic send_rx(input logic [DW-1:0] d);
        rx_tdata  = d;
        rx_tvalid = 1'b1;
        @(negedge clk);
        rx_tvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (rx_tready !== 1'b0) begin fails++; $display("FAIL reset_rx_tready: got %0b want 0", rx_tready); end
        checks++; if ({pass_cnt, fail_cnt, unexp_cnt} !== '0) begin fails++; $display("FAIL reset_counters: got %0h/%0h/%0h want 0", pass_cnt, fail_cnt, unexp_cnt); end
        checks++; if (outstanding !== '0) begin fails++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
        checks++; if ({timeout, mismatch} !== 2'b00) begin fails++; $display("FAIL reset_flags: got %0b%0b want 00", timeout, mismatch); end
        checks++; if ({last_rx, last_exp} !== '0) begin fails++; $display("FAIL reset_last: got %0h/%0h want 0", last_rx, last_exp); end
        checks++; if (idle !== 1'b1) begin fails++; $display("FAIL reset_idle: got %0b want 1", idle); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (rx_tready !== 1'b1) begin fails++; $display("FAIL post_reset_rx_tready: got %0b want 1", rx_tready); end
    endtask

    task automatic test_loopback();
        bit ok;
        bit saw_mm;
        pulse_clear();
        send_cmd(8'h5A, 8'h5A, ok);
        checks++; if (!ok) begin fails++; $display("FAIL loop_cmd_hs: got none want handshake"); end
        checks++; if (outstanding !== OW'(1)) begin fails++; $display("FAIL loop_outstanding: got %0d want 1", outstanding); end
        saw_mm = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (mismatch) saw_mm = 1'b1;
        end
        send_rx(8'h5A);
        if (mismatch) saw_mm = 1'b1;
        checks++; if (pass_cnt !== CW'(1)) begin fails++; $display("FAIL loop_pass: got %0d want 1", pass_cnt); end
        checks++; if (fail_cnt !== '0) begin fails++; $display("FAIL loop_fail: got %0d want 0", fail_cnt); end
        checks++; if (saw_mm !== 1'b0) begin fails++; $display("FAIL loop_mismatch: got 1 want 0"); end
        checks++; if (idle !== 1'b1 || outstanding !== '0) begin fails++; $display("FAIL loop_idle: got %0b/%0d want 1/0", idle, outstanding); end
        checks++; if (last_rx !== 8'h5A) begin fails++; $display("FAIL loop_last_rx: got %0h want 5a", last_rx); end
    endtask

    task automatic test_mismatch();
        pulse_clear();
        cmd_tdata  = {8'h07, 8'h03};
        cmd_tvalid = 1'b1;
        tx_tready  = 1'b1;
        #1;
        checks++; if (tx_tdata !== 8'h03 || tx_tvalid !== 1'b1) begin fails++; $display("FAIL mm_tx: got %0h/%0b want 03/1", tx_tdata, tx_tvalid); end
        @(negedge clk);
        cmd_tvalid = 1'b0;
        repeat (5) @(negedge clk);
        send_rx(8'h06);
        checks++; if (fail_cnt !== CW'(1) || pass_cnt !== '0) begin fails++; $display("FAIL mm_counts: got %0d/%0d want 0/1", pass_cnt, fail_cnt); end
        checks++; if (mismatch !== 1'b1) begin fails++; $display("FAIL mm_pulse: got %0b want 1", mismatch); end
        checks++; if (last_exp !== 8'h07 || last_rx !== 8'h06) begin fails++; $display("FAIL mm_last: got %0h/%0h want 07/06", last_exp, last_rx); end
        @(negedge clk);
        checks++; if (mismatch !== 1'b0) begin fails++; $display("FAIL mm_pulse_len: got %0b want 0", mismatch); end
    endtask

    task automatic test_full();
        int acc;
        pulse_clear();
        acc        = 0;
        tx_tready  = 1'b1;
        cmd_tvalid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            cmd_tdata = {8'(8'h20 + i), 8'(i)};
            #1;
            if (cmd_tready) acc++;
            @(negedge clk);
        end
        checks++; if (acc !== 16) begin fails++; $display("FAIL full_accepted: got %0d want 16", acc); end
        checks++; if (cmd_tready !== 1'b0 || tx_tvalid !== 1'b0) begin fails++; $display("FAIL full_stall: got %0b/%0b want 0/0", cmd_tready, tx_tvalid); end
        checks++; if (outstanding !== OW'(16)) begin fails++; $display("FAIL full_outstanding: got %0d want 16", outstanding); end
        rx_tdata  = 8'h20;
        rx_tvalid = 1'b1;
        #1;
        checks++; if (cmd_tready !== 1'b0) begin fails++; $display("FAIL full_no_bypass: got %0b want 0", cmd_tready); end
        @(negedge clk);
        rx_tvalid = 1'b0;
        checks++; if (outstanding !== OW'(15) || pass_cnt !== CW'(1)) begin fails++; $display("FAIL full_pop: got %0d/%0d want 15/1", outstanding, pass_cnt); end
        @(negedge clk);
        cmd_tvalid = 1'b0;
        checks++; if (outstanding !== OW'(16)) begin fails++; $display("FAIL full_refill: got %0d want 16", outstanding); end
    endtask

    task automatic test_timeout();
        bit ok;
        int rise;
        pulse_clear();
        send_cmd(8'h33, 8'h44, ok);
        repeat (99) @(negedge clk);
        send_rx(8'h33);
        checks++; if (pass_cnt !== CW'(1) || timeout !== 1'b0) begin fails++; $display("FAIL to_late_rx: got %0d/%0b want 1/0", pass_cnt, timeout); end
        repeat (150) @(negedge clk);
        checks++; if (timeout !== 1'b0 || fail_cnt !== '0) begin fails++; $display("FAIL to_no_timeout: got %0b/%0d want 0/0", timeout, fail_cnt); end
        pulse_clear();
        send_cmd(8'h55, 8'h66, ok);
        rise = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (timeout) begin
                rise = k;
                break;
            end
        end
        checks++; if (rise !== 101) begin fails++; $display("FAIL to_rise: got %0d want 101", rise); end
        checks++; if (fail_cnt !== CW'(1) || outstanding !== '0) begin fails++; $display("FAIL to_counts: got %0d/%0d want 1/0", fail_cnt, outstanding); end
        checks++; if (last_exp !== 8'h55 || mismatch !== 1'b0) begin fails++; $display("FAIL to_last: got %0h/%0b want 55/0", last_exp, mismatch); end
    endtask

    task automatic test_unexpected_clear();
        send_rx(8'hFF);
        checks++; if (unexp_cnt !== CW'(1)) begin fails++; $display("FAIL unexp_cnt: got %0d want 1", unexp_cnt); end
        checks++; if (pass_cnt !== '0 || fail_cnt !== CW'(1)) begin fails++; $display("FAIL unexp_pf: got %0d/%0d want 0/1", pass_cnt, fail_cnt); end
        checks++; if (last_rx !== 8'h00 || last_exp !== 8'h55) begin fails++; $display("FAIL unexp_last: got %0h/%0h want 00/55", last_rx, last_exp); end
        clear     = 1'b1;
        tx_tready = 1'b1;
        #1;
        checks++; if (cmd_tready !== 1'b0) begin fails++; $display("FAIL clr_cmd_tready: got %0b want 0", cmd_tready); end
        @(negedge clk);
        clear = 1'b0;
        checks++; if ({pass_cnt, fail_cnt, unexp_cnt} !== '0) begin fails++; $display("FAIL clr_counters: got %0h/%0h/%0h want 0", pass_cnt, fail_cnt, unexp_cnt); end
        checks++; if (timeout !== 1'b0 || rx_tready !== 1'b1) begin fails++; $display("FAIL clr_flags: got %0b/%0b want 0/1", timeout, rx_tready); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        pulse_clear();
        send_cmd(8'h21, 8'h21, ok);
        send_rx(8'h21);
        for (int i = 0; i < 5; i++) send_cmd(8'(8'h30 + i), 8'(i), ok);
        checks++; if (outstanding !== OW'(5) || pass_cnt !== CW'(1)) begin fails++; $display("FAIL rm_before: got %0d/%0d want 5/1", outstanding, pass_cnt); end
        rst_n = 1'b0;
        #1;
        checks++; if (outstanding !== '0 || pass_cnt !== '0) begin fails++; $display("FAIL rm_async: got %0d/%0d want 0/0", outstanding, pass_cnt); end
        checks++; if (rx_tready !== 1'b0 || idle !== 1'b1) begin fails++; $display("FAIL rm_ready: got %0b/%0b want 0/1", rx_tready, idle); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_cmd(8'h11, 8'h11, ok);
        repeat (3) @(negedge clk);
        send_rx(8'h11);
        checks++; if (pass_cnt !== CW'(1) || fail_cnt !== '0 || unexp_cnt !== '0) begin fails++; $display("FAIL rm_fresh: got %0d/%0d/%0d want 1/0/0", pass_cnt, fail_cnt, unexp_cnt); end
        checks++; if (idle !== 1'b1) begin fails++; $display("FAIL rm_idle: got %0b want 1", idle); end
    endtask

    task automatic test_random();
        bit quiet;
        bit room;
        pulse_clear();
        for (int c = 0; c < 3000; c++) begin
            checks++; if (pass_cnt !== CW'(m_pass)) begin fails++; $display("FAIL rnd_pass c=%0d: got %0d want %0d", c, pass_cnt, m_pass); end
            checks++; if (fail_cnt !== CW'(m_fail)) begin fails++; $display("FAIL rnd_fail c=%0d: got %0d want %0d", c, fail_cnt, m_fail); end
            checks++; if (unexp_cnt !== CW'(m_unexp)) begin fails++; $display("FAIL rnd_unexp c=%0d: got %0d want %0d", c, unexp_cnt, m_unexp); end
            checks++; if (outstanding !== OW'(mq.size())) begin fails++; $display("FAIL rnd_outstanding c=%0d: got %0d want %0d", c, outstanding, mq.size()); end
            checks++; if (mismatch !== m_mismatch || timeout !== m_timeout) begin fails++; $display("FAIL rnd_flags c=%0d: got %0b/%0b want %0b/%0b", c, mismatch, timeout, m_mismatch, m_timeout); end
            checks++; if (last_rx !== m_last_rx || last_exp !== m_last_exp) begin fails++; $display("FAIL rnd_last c=%0d: got %0h/%0h want %0h/%0h", c, last_rx, last_exp, m_last_rx, m_last_exp); end
            checks++; if (rx_tready !== m_rxrdy) begin fails++; $display("FAIL rnd_rx_tready c=%0d: got %0b want %0b", c, rx_tready, m_rxrdy); end
            quiet      = (c % 600) >= 420;
            cmd_tvalid = ($urandom_range(0, 2) != 0);
            cmd_tdata  = (2*DW)'($urandom);
            tx_tready  = ($urandom_range(0, 3) != 0);
            rx_tvalid  = !quiet && ($urandom_range(0, 3) == 0);
            if (mq.size() > 0 && $urandom_range(0, 3) != 0) rx_tdata = mq[0];
            else rx_tdata = DW'($urandom);
            clear = ($urandom_range(0, 499) == 0);
            room  = (mq.size() < DEPTH);
            #1;
            checks++; if (cmd_tready !== (tx_tready && room && !clear)) begin fails++; $display("FAIL rnd_cmd_tready c=%0d: got %0b", c, cmd_tready); end
            checks++; if (tx_tvalid !== (cmd_tvalid && room) || tx_tdata !== cmd_tdata[DW-1:0]) begin fails++; $display("FAIL rnd_tx c=%0d: got %0b/%0h", c, tx_tvalid, tx_tdata); end
            checks++; if (idle !== (mq.size() == 0 && !cmd_tvalid)) begin fails++; $display("FAIL rnd_idle c=%0d: got %0b", c, idle); end
            @(negedge clk);
        end
        clear      = 1'b0;
        cmd_tvalid = 1'b0;
        rx_tvalid  = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_loopback();
        test_mismatch();
        test_full();
        test_timeout();
        test_unexpected_clear();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
